// File: rtl/mem_pkg.sv
// Shared definitions for the load/store bus interface: access size codes,
// FSM state encoding, byte-enable constants and store-side helpers.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_ALL     = 4'b1111;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  // A request is legal when it is one direction only, uses a defined size
  // code (unsigned codes are loads only) and is naturally aligned.
  function automatic logic access_legal(input logic rd, input logic wr,
                                        input logic [2:0] f3,
                                        input logic [1:0] a);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_BU: ok = 1'b1;
      F3_H, F3_HU: ok = ~a[0];
      F3_W:        ok = (a == 2'b00);
      default:     ok = 1'b0;
    endcase
    if (wr && f3[2]) ok = 1'b0;
    if (rd && wr)    ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = BE_BYTE0 << a;
      2'b01:   be = a[1] ? BE_HALF_HI : BE_HALF_LO;
      default: be = BE_ALL;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] data);
    logic [31:0] w;
    case (f3[1:0])
      2'b00:   w = {4{data[7:0]}};
      2'b01:   w = {2{data[15:0]}};
      default: w = data;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load formatter: selects the addressed byte/halfword lane of a
// bus word and sign- or zero-extends it to 32 bits.
module load_extend
  import mem_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  lanes [4];
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lanes[gi] = word[8*gi +: 8];
  end

  always_comb begin
    byte_lane = lanes[byte_off];
    half_lane = byte_off[1] ? word[31:16] : word[15:0];
    case (func3)
      F3_B:    data = {{24{byte_lane[7]}}, byte_lane};
      F3_BU:   data = {24'h0, byte_lane};
      F3_H:    data = {{16{half_lane[15]}}, half_lane};
      F3_HU:   data = {16'h0, half_lane};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/lsu_bus_if.sv
// Load/store unit bus interface: turns one datapath memory instruction into a
// single word-aligned bus transaction with a bounded wait and stall control.
module lsu_bus_if
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] wr_mem_data,
  output logic [31:0] rd_mem_data,
  output logic        stall,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_e       state_reg, state_next;
  logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic [2:0]       func3_reg;
  logic [1:0]       off_reg;

  logic        req_valid;
  logic        req_legal;
  logic        issue;
  logic        ack_seen;
  logic        timeout;
  logic [31:0] load_data;

  assign req_valid = mem_read | mem_write;
  assign req_legal = access_legal(mem_read, mem_write, func3, addr[1:0]);
  assign issue     = (state_reg == ST_IDLE) && req_valid && req_legal;
  assign ack_seen  = (state_reg == ST_BUS) && bus_ack;
  // The final unacknowledged cycle is the one whose count would reach TIMEOUT.
  assign timeout   = (state_reg == ST_BUS) && !bus_ack && (wait_cnt_reg == CNT_LAST);

  load_extend u_load_extend (
    .func3    (func3_reg),
    .byte_off (off_reg),
    .word     (bus_rdata),
    .data     (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        wait_cnt_next = '0;
        if (issue) state_next = ST_BUS;
      end
      ST_BUS: begin
        if (bus_ack || timeout) state_next = ST_DONE;
        else                    wait_cnt_next = wait_cnt_reg + 1'b1;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Held low during reset even though the instruction inputs may still be live.
  always_comb begin
    stall    = rst_n && (issue || (state_reg == ST_BUS));
    misalign = rst_n && (state_reg == ST_IDLE) && req_valid && !req_legal;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_be      <= BE_NONE;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      rd_mem_data <= '0;
      bus_err     <= 1'b0;
      func3_reg   <= F3_B;
      off_reg     <= 2'b00;
    end else begin
      bus_err <= 1'b0;
      if (issue) begin
        bus_req   <= 1'b1;
        bus_we    <= mem_write;
        bus_addr  <= {addr[31:2], 2'b00};
        bus_be    <= mem_write ? store_be(func3, addr[1:0]) : BE_ALL;
        bus_wdata <= mem_write ? store_wdata(func3, wr_mem_data) : '0;
        func3_reg <= func3;
        off_reg   <= addr[1:0];
      end
      if (ack_seen) begin
        bus_req <= 1'b0;
        if (!bus_we) rd_mem_data <= load_data;
      end else if (timeout) begin
        bus_req     <= 1'b0;
        bus_err     <= 1'b1;
        rd_mem_data <= '0;
      end
    end
  end

endmodule

// File: tb/tb_lsu_bus_if.sv
// Scoreboard bench for lsu_bus_if: a driver pushes expected bus events from a
// behavioural model, a negedge monitor pops and compares them.
module tb_lsu_bus_if;

  localparam int TIMEOUT = 255;
  localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write;
  logic [2:0]  func3;
  logic [31:0] addr, wr_mem_data;
  logic [31:0] rd_mem_data;
  logic        stall, misalign, bus_err, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  always #5 clk = ~clk;

  lsu_bus_if #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .func3(func3), .addr(addr), .wr_mem_data(wr_mem_data),
    .rd_mem_data(rd_mem_data), .stall(stall), .misalign(misalign),
    .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  typedef enum {EV_MIS, EV_REQ, EV_RESP} ev_e;
  typedef struct {
    ev_e         kind;
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          stall_cycles;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] rd_model = '0;
  bit          mon_en = 1'b0;
  bit          prev_req = 1'b0;
  int          stall_cnt = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endfunction

  function automatic bit pop_exp(ev_e k, output exp_t e);
    n_checks++;
    e = '{kind: EV_MIS, addr: 0, be: 0, we: 0, wdata: 0, rdata: 0, err: 0, stall_cycles: 0};
    if (exp_q.size() == 0) begin
      $display("FAIL event_%s: DUT produced event, nothing expected", k.name());
      return 1'b0;
    end
    e = exp_q.pop_front();
    if (e.kind != k) begin
      $display("FAIL event_%s: got %s expected %s", k.name(), k.name(), e.kind.name());
      return 1'b0;
    end
    n_pass++;
    return 1'b1;
  endfunction

  // ---------------- behavioural reference model ----------------
  function automatic int size_of(logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit model_legal(bit rd, bit wr, logic [2:0] f3, logic [31:0] a);
    int sz;
    sz = size_of(f3);
    if (rd && wr) return 1'b0;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b0;
    if (wr && f3[2]) return 1'b0;
    return (int'(a[1:0]) % sz) == 0;
  endfunction

  function automatic logic [31:0] model_load(logic [2:0] f3, logic [31:0] a, logic [31:0] w);
    int sz;
    logic [31:0] v;
    sz = size_of(f3);
    v  = w >> (8 * int'(a[1:0]));
    if (sz == 1) v = v & 32'h0000_00FF;
    if (sz == 2) v = v & 32'h0000_FFFF;
    if (!f3[2] && sz == 1 && v[7])  v = v | 32'hFFFF_FF00;
    if (!f3[2] && sz == 2 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  function automatic logic [3:0] model_be(logic [2:0] f3, logic [31:0] a);
    int sz;
    logic [3:0] one, two;
    sz  = size_of(f3);
    one = 4'b0001;
    two = 4'b0011;
    if (sz == 1) return one << a[1:0];
    if (sz == 2) return two << a[1:0];
    return 4'b1111;
  endfunction

  function automatic logic [31:0] model_wdata(logic [2:0] f3, logic [31:0] d);
    int sz;
    sz = size_of(f3);
    if (sz == 1) return {24'h0, d[7:0]} * 32'h0101_0101;
    if (sz == 2) return {16'h0, d[15:0]} * 32'h0001_0001;
    return d;
  endfunction

  // ---------------- driver ----------------
  // Entered and left #1 after a rising edge. delay = cycle of BUS in which ack
  // arrives; delay 0 means the bus never answers.
  task automatic do_txn(bit rd, bit wr, logic [2:0] f3, logic [31:0] a,
                        logic [31:0] d, int delay, logic [31:0] rdata);
    exp_t e;
    mem_read = rd; mem_write = wr; func3 = f3; addr = a; wr_mem_data = d;
    e = '{kind: EV_MIS, addr: 0, be: 0, we: 0, wdata: 0, rdata: 0, err: 0, stall_cycles: 0};
    if (!rd && !wr) begin
      @(posedge clk); #1;
      return;
    end
    if (!model_legal(rd, wr, f3, a)) begin
      exp_q.push_back(e);
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0;
      return;
    end
    e.kind  = EV_REQ;
    e.addr  = {a[31:2], 2'b00};
    e.be    = wr ? model_be(f3, a) : 4'b1111;
    e.we    = wr;
    e.wdata = model_wdata(f3, d);
    exp_q.push_back(e);
    if (delay == 0) begin
      rd_model       = '0;
      e.err          = 1'b1;
      e.stall_cycles = TIMEOUT + 1;
    end else begin
      if (rd) rd_model = model_load(f3, a, rdata);
      e.err          = 1'b0;
      e.stall_cycles = delay + 1;
    end
    e.kind  = EV_RESP;
    e.rdata = rd_model;
    exp_q.push_back(e);
    if (delay == 0) begin
      repeat (TIMEOUT + 1) @(posedge clk);
    end else begin
      repeat (delay) @(posedge clk);
      #1 bus_ack = 1'b1; bus_rdata = rdata;
      @(posedge clk);
    end
    #1 bus_ack = 1'b0; bus_rdata = $urandom;
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  // Idle cycles with stray acks that must be ignored outside BUS.
  task automatic gap(int n);
    repeat (n) begin
      bus_ack = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
      @(posedge clk); #1;
    end
    bus_ack = 1'b0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (!mon_en) begin
      prev_req  = 1'b0;
      stall_cnt = 0;
    end else begin
      if (stall) stall_cnt++;
      if (misalign) begin
        void'(pop_exp(EV_MIS, e));
        chk("misalign_stall", stall, 1'b0);
        chk("misalign_bus_req", bus_req, 1'b0);
      end
      if (bus_req && !prev_req) begin
        if (pop_exp(EV_REQ, e)) begin
          cur = e;
          chk("req_addr", bus_addr, e.addr);
          chk("req_be", bus_be, e.be);
          chk("req_we", bus_we, e.we);
          if (e.we) chk("req_wdata", bus_wdata, e.wdata);
        end
      end else if (bus_req) begin
        chk("req_stable_addr", bus_addr, cur.addr);
        chk("req_stable_be", bus_be, cur.be);
      end
      if (!bus_req && prev_req) begin
        if (pop_exp(EV_RESP, e)) begin
          chk("resp_rd_mem_data", rd_mem_data, e.rdata);
          chk("resp_bus_err", bus_err, e.err);
          chk("resp_stall_cycles", stall_cnt, e.stall_cycles);
          chk("resp_stall_released", stall, 1'b0);
        end
        stall_cnt = 0;
      end else if (bus_err) begin
        chk("bus_err_spurious", bus_err, 1'b0);
      end
      prev_req = bus_req;
    end
  end

  initial begin
    #5_000_000;
    n_checks++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; func3 = '0;
    addr = '0; wr_mem_data = '0; bus_ack = 1'b0; bus_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_bus_req", bus_req, 1'b0);
    chk("reset_bus_be", bus_be, 4'b0000);
    chk("reset_bus_addr", bus_addr, 32'h0);
    chk("reset_rd_mem_data", rd_mem_data, 32'h0);
    chk("reset_stall", stall, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    do_txn(1, 0, LW, 32'h100, 0, 3, 32'hDEAD_BEEF);
    chk("lw_deadbeef", rd_mem_data, 32'hDEAD_BEEF);
    do_txn(1, 0, LB, 32'h103, 0, 2, 32'h8011_2233);
    chk("lb_sign", rd_mem_data, 32'hFFFF_FF80);
    do_txn(1, 0, LBU, 32'h103, 0, 1, 32'h8011_2233);
    chk("lbu_zero", rd_mem_data, 32'h0000_0080);
    do_txn(0, 1, LH, 32'h22, 32'h0000_ABCD, 2, 32'h0);
    do_txn(1, 0, LW, 32'h102, 0, 1, 32'h0);
    gap(2);
    do_txn(1, 0, LW, 32'h200, 0, 0, 32'h0);
    chk("timeout_rd_zero", rd_mem_data, 32'h0);

    for (int i = 0; i < 200; i++) begin
      int          sel, sz, dly;
      bit          rd, wr;
      logic [2:0]  f3;
      logic [31:0] a;
      sel = $urandom_range(0, 99);
      f3  = 3'($urandom_range(0, 7));
      a   = $urandom;
      sz  = size_of(f3);
      if ($urandom_range(0, 2) != 0) begin
        if (sz == 2) a[0] = 1'b0;
        if (sz == 4) a[1:0] = 2'b00;
      end
      rd  = (sel < 45) || (sel >= 90 && sel < 95);
      wr  = (sel >= 45 && sel < 95);
      dly = $urandom_range(1, 5);
      if ($urandom_range(0, 59) == 0) dly = 0;
      do_txn(rd, wr, f3, a, $urandom, dly, $urandom);
      gap($urandom_range(0, 2));
    end

    // Reset in the middle of a bus access, then a late ack.
    mon_en = 1'b0;
    mem_read = 1'b1; func3 = LW; addr = 32'h300;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_reset_bus_req", bus_req, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_bus_req_drop", bus_req, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    mem_read = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
    repeat (2) begin
      @(negedge clk);
      chk("late_ack_bus_req", bus_req, 1'b0);
      chk("late_ack_stall", stall, 1'b0);
      chk("late_ack_rd", rd_mem_data, 32'h0);
    end
    @(posedge clk); #1;
    bus_ack = 1'b0;
    rd_model = '0;
    mon_en = 1'b1;
    do_txn(1, 0, LH, 32'h302, 0, 2, 32'hC001_7777);
    chk("post_reset_lh", rd_mem_data, 32'hFFFF_C001);
    gap(2);

    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
